// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared defaults and configuration helpers for pipe_adder
package pipe_adder_pkg;

    localparam int PA_WIDTH_DEF  = 8;
    localparam int PA_STAGES_DEF = 2;

    function automatic int pa_chunk(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit pa_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
interface pipe_adder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, ci, sub, in_valid, out_ready,
        input  in_ready, s, co, ovf, out_valid
    );

    modport slave (
        input  a, b, ci, sub, in_valid, out_ready,
        output in_ready, s, co, ovf, out_valid
    );
endinterface

// File: rtl/pipe_adder_stage.sv
// rtl/pipe_adder_stage.sv - one registered CHUNK-bit ripple stage of pipe_adder
module pipe_adder_stage #(
    parameter int CHUNK = 4,
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             up_valid,
    input  logic             down_ready,
    output logic             valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] bp_in,
    input  logic [WIDTH-1:0] r_in,
    input  logic             c_in,
    input  logic             am_in,
    input  logic             bm_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] bp_out,
    output logic [WIDTH-1:0] r_out,
    output logic             c_out,
    output logic             am_out,
    output logic             bm_out
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d, bp_q, bp_d, r_q, r_d;
    logic             c_q, c_d, am_q, am_d, bm_q, bm_d;
    logic [CHUNK-1:0] sum;
    logic             carry;
    logic             load;

    // The unprocessed operand bits always sit at the bottom, so every stage
    // works on bits [CHUNK-1:0]; finished chunks enter the result at the top
    // and shift down, landing in place after the last stage.
    always_comb begin
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a_in[i] ^ bp_in[i] ^ carry;
            carry  = (a_in[i] & bp_in[i]) | (carry & (a_in[i] ^ bp_in[i]));
        end
    end

    always_comb begin
        load    = !valid_q || down_ready;
        valid_d = load ? up_valid : valid_q;
        a_d     = a_q;
        bp_d    = bp_q;
        r_d     = r_q;
        c_d     = c_q;
        am_d    = am_q;
        bm_d    = bm_q;
        if (load && up_valid) begin
            a_d  = a_in >> CHUNK;
            bp_d = bp_in >> CHUNK;
            r_d  = (r_in >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
            c_d  = carry;
            am_d = am_in;
            bm_d = bm_in;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            bp_q    <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            bp_q    <= bp_d;
            r_q     <= r_d;
            c_q     <= c_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
        end
    end

    assign valid  = valid_q;
    assign a_out  = a_q;
    assign bp_out = bp_q;
    assign r_out  = r_q;
    assign c_out  = c_q;
    assign am_out = am_q;
    assign bm_out = bm_q;

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/subtract with carry registered between chunk stages
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = PA_WIDTH_DEF,
    parameter int STAGES = PA_STAGES_DEF
) (
    input  logic ck,
    input  logic rst,
    pipe_adder_if.slave io
);

    localparam int CHUNK = pa_chunk(WIDTH, STAGES);

    if (!pa_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic [WIDTH-1:0] a_c  [STAGES+1];
    logic [WIDTH-1:0] bp_c [STAGES+1];
    logic [WIDTH-1:0] r_c  [STAGES+1];
    logic             c_c  [STAGES+1];
    logic             am_c [STAGES+1];
    logic             bm_c [STAGES+1];
    logic             vld_c[STAGES+1];
    logic             down_rdy[STAGES];
    logic             chain_rdy;
    logic [WIDTH-1:0] bp0;
    logic             unused_tail;

    always_comb begin
        bp0 = io.sub ? ~io.b : io.b;
    end

    assign a_c[0]   = io.a;
    assign bp_c[0]  = bp0;
    assign r_c[0]   = '0;
    assign c_c[0]   = io.sub ? ~io.ci : io.ci;
    assign am_c[0]  = io.a[WIDTH-1];
    assign bm_c[0]  = bp0[WIDTH-1];
    assign vld_c[0] = io.in_valid;

    // A stage may advance if anything downstream of it has room or the
    // consumer takes the head, so the ready chain is an OR over empty stages.
    always_comb begin
        chain_rdy = io.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            down_rdy[k] = chain_rdy;
            chain_rdy   = chain_rdy || !vld_c[k+1];
        end
        io.in_ready = chain_rdy;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .CHUNK(CHUNK),
            .WIDTH(WIDTH)
        ) u_stage (
            .ck        (ck),
            .rst       (rst),
            .up_valid  (vld_c[k]),
            .down_ready(down_rdy[k]),
            .valid     (vld_c[k+1]),
            .a_in      (a_c[k]),
            .bp_in     (bp_c[k]),
            .r_in      (r_c[k]),
            .c_in      (c_c[k]),
            .am_in     (am_c[k]),
            .bm_in     (bm_c[k]),
            .a_out     (a_c[k+1]),
            .bp_out    (bp_c[k+1]),
            .r_out     (r_c[k+1]),
            .c_out     (c_c[k+1]),
            .am_out    (am_c[k+1]),
            .bm_out    (bm_c[k+1])
        );
    end

    assign unused_tail  = ^{a_c[STAGES], bp_c[STAGES]};

    assign io.s         = r_c[STAGES];
    assign io.co        = c_c[STAGES];
    assign io.out_valid = vld_c[STAGES];
    assign io.ovf       = (am_c[STAGES] == bm_c[STAGES]) && (r_c[STAGES][WIDTH-1] != am_c[STAGES]);

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder in four width/stage configurations
module tb_pipe_adder;

    localparam int N = 4;
    localparam int W [N] = '{8, 8, 16, 32};
    localparam int ST[N] = '{2, 1, 4, 8};

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ovf;
        int          cyc;
        bit          lat;
    } exp_t;

    logic ck = 1'b0;
    logic rst = 1'b0;
    always #5 ck = ~ck;

    logic [31:0] ta[N], tbv[N], ts[N];
    logic        tci[N], tsub[N], tiv[N], tordy[N];
    logic        tco[N], tovf[N], tov[N], tir[N];

    exp_t q[N][$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_rdy = 0;
    bit   exp_rdy = 1;
    bit   end_chk = 0;

    always @(posedge ck) cyc <= cyc + 1;

    pipe_adder_if #(.WIDTH(8))  if0 ();
    pipe_adder_if #(.WIDTH(8))  if1 ();
    pipe_adder_if #(.WIDTH(16)) if2 ();
    pipe_adder_if #(.WIDTH(32)) if3 ();

    pipe_adder #(.WIDTH(8),  .STAGES(2)) u0 (.ck(ck), .rst(rst), .io(if0.slave));
    pipe_adder #(.WIDTH(8),  .STAGES(1)) u1 (.ck(ck), .rst(rst), .io(if1.slave));
    pipe_adder #(.WIDTH(16), .STAGES(4)) u2 (.ck(ck), .rst(rst), .io(if2.slave));
    pipe_adder #(.WIDTH(32), .STAGES(8)) u3 (.ck(ck), .rst(rst), .io(if3.slave));

    assign if0.a = ta[0][7:0];  assign if0.b = tbv[0][7:0];  assign if0.ci = tci[0]; assign if0.sub = tsub[0];
    assign if0.in_valid = tiv[0]; assign if0.out_ready = tordy[0];
    assign ts[0] = {24'b0, if0.s}; assign tco[0] = if0.co; assign tovf[0] = if0.ovf;
    assign tov[0] = if0.out_valid; assign tir[0] = if0.in_ready;

    assign if1.a = ta[1][7:0];  assign if1.b = tbv[1][7:0];  assign if1.ci = tci[1]; assign if1.sub = tsub[1];
    assign if1.in_valid = tiv[1]; assign if1.out_ready = tordy[1];
    assign ts[1] = {24'b0, if1.s}; assign tco[1] = if1.co; assign tovf[1] = if1.ovf;
    assign tov[1] = if1.out_valid; assign tir[1] = if1.in_ready;

    assign if2.a = ta[2][15:0]; assign if2.b = tbv[2][15:0]; assign if2.ci = tci[2]; assign if2.sub = tsub[2];
    assign if2.in_valid = tiv[2]; assign if2.out_ready = tordy[2];
    assign ts[2] = {16'b0, if2.s}; assign tco[2] = if2.co; assign tovf[2] = if2.ovf;
    assign tov[2] = if2.out_valid; assign tir[2] = if2.in_ready;

    assign if3.a = ta[3];       assign if3.b = tbv[3];       assign if3.ci = tci[3]; assign if3.sub = tsub[3];
    assign if3.in_valid = tiv[3]; assign if3.out_ready = tordy[3];
    assign ts[3] = if3.s; assign tco[3] = if3.co; assign tovf[3] = if3.ovf;
    assign tov[3] = if3.out_valid; assign tir[3] = if3.in_ready;

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sub, input int c);
        exp_t        e;
        logic [63:0] m, av, bp, full;
        m    = (64'd1 << w) - 64'd1;
        av   = {32'b0, a} & m;
        bp   = (sub ? ~{32'b0, b} : {32'b0, b}) & m;
        full = av + bp + {63'b0, (sub ? ~ci : ci)};
        e.s   = full[31:0] & m[31:0];
        e.co  = full[w];
        e.ovf = (av[w-1] == bp[w-1]) && (full[w-1] != av[w-1]);
        e.cyc = c;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    initial begin : monitor
        bit   seen[N];
        bit   end_done;
        exp_t e;
        end_done = 0;
        for (int i = 0; i < N; i++) seen[i] = 0;
        forever begin
            @(negedge ck or negedge rst);
            #1;
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    seen[i] = 0;
                    chk($sformatf("rst_out_valid%0d", i), 32'(tov[i]), 32'd0);
                    chk($sformatf("rst_s%0d", i), ts[i], 32'd0);
                    chk($sformatf("rst_co%0d", i), 32'(tco[i]), 32'd0);
                    chk($sformatf("rst_ovf%0d", i), 32'(tovf[i]), 32'd0);
                    chk($sformatf("rst_in_ready%0d", i), 32'(tir[i]), 32'd1);
                end
            end else begin
                if (chk_rdy) chk("in_ready", 32'(tir[0]), 32'(exp_rdy));
                for (int i = 0; i < N; i++) begin
                    if (tov[i]) begin
                        if (q[i].size() == 0) begin
                            chk($sformatf("unexpected_out%0d", i), 32'(tov[i]), 32'd0);
                        end else begin
                            e = q[i][0];
                            chk($sformatf("s%0d", i), ts[i], e.s);
                            chk($sformatf("co%0d", i), 32'(tco[i]), 32'(e.co));
                            chk($sformatf("ovf%0d", i), 32'(tovf[i]), 32'(e.ovf));
                            if (e.lat && !seen[i])
                                chk($sformatf("latency%0d", i), 32'(cyc - e.cyc), 32'(ST[i]));
                            seen[i] = 1;
                            if (tordy[i]) begin
                                void'(q[i].pop_front());
                                seen[i] = 0;
                            end
                        end
                    end
                end
                if (end_chk && !end_done) begin
                    for (int i = 0; i < N; i++)
                        chk($sformatf("leftover%0d", i), 32'(q[i].size()), 32'd0);
                    end_done = 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ck);
            #2;
        end
    endtask

    task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb,
                         input logic [7:0] es, input logic eco, input logic eovf, input bit lat);
        bit acc;
        exp_t e;
        acc = 0;
        ta[0] = {24'b0, a}; tbv[0] = {24'b0, b}; tci[0] = c; tsub[0] = sb; tiv[0] = 1'b1;
        e.s = {24'b0, es}; e.co = eco; e.ovf = eovf; e.lat = lat;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge ck);
            acc = tir[0];
            e.cyc = cyc;
            if (acc) q[0].push_back(e);
            @(posedge ck);
            #2;
        end
        if (!acc) q[0].push_back(e);
        tiv[0] = 1'b0;
    endtask

    initial begin : stim
        for (int i = 0; i < N; i++) begin
            ta[i] = '0; tbv[i] = '0; tci[i] = 0; tsub[i] = 0; tiv[i] = 0; tordy[i] = 1;
        end
        tiv[0] = 1; ta[0] = $urandom; tbv[0] = $urandom;
        repeat (3) @(posedge ck);
        #2;
        rst = 1; tiv[0] = 0;
        idle(4);

        send0(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
        send0(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 1);
        send0(8'h10, 8'h20, 0, 1, 8'hF0, 0, 0, 1);
        send0(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 1);
        send0(8'h05, 8'h02, 1, 1, 8'h02, 1, 0, 1);
        idle(3);

        chk_rdy = 1; exp_rdy = 1;
        for (int i = 0; i < 8; i++) send0(8'(i), 8'(i), i[0], 0, 8'(2 * i + i[0]), 0, 0, 1);
        idle(4);

        tordy[0] = 0;
        send0(8'h11, 8'h22, 0, 0, 8'h33, 0, 0, 0);
        send0(8'h40, 8'h40, 0, 0, 8'h80, 0, 1, 0);
        exp_rdy = 0;
        ta[0] = 32'h01; tbv[0] = 32'h01; tci[0] = 0; tsub[0] = 0; tiv[0] = 1;
        idle(3);
        tordy[0] = 1; chk_rdy = 0;
        send0(8'h01, 8'h01, 0, 0, 8'h02, 0, 0, 0);
        send0(8'hC0, 8'h50, 1, 1, 8'h6F, 1, 1, 0);
        idle(4);

        tordy[0] = 0; chk_rdy = 1; exp_rdy = 1;
        send0(8'h0A, 8'h0B, 1, 0, 8'h16, 0, 0, 0);
        idle(2);
        send0(8'h90, 8'h90, 0, 0, 8'h20, 1, 1, 0);
        exp_rdy = 0;
        ta[0] = 32'h03; tbv[0] = 32'h04; tiv[0] = 1;
        idle(2);
        tordy[0] = 1; chk_rdy = 0;
        send0(8'h03, 8'h04, 0, 0, 8'h07, 0, 0, 0);
        idle(4);

        tordy[0] = 0;
        send0(8'h21, 8'h12, 0, 0, 8'h33, 0, 0, 0);
        send0(8'h44, 8'h33, 0, 0, 8'h77, 0, 0, 0);
        rst = 0;
        for (int i = 0; i < N; i++) q[i].delete();
        idle(2);
        rst = 1; tordy[0] = 1;
        idle(5);

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                ta[i] = $urandom; tbv[i] = $urandom;
                tci[i] = 1'($urandom_range(0, 1)); tsub[i] = 1'($urandom_range(0, 1));
                tiv[i] = ($urandom_range(0, 3) != 0);
                tordy[i] = ($urandom_range(0, 3) != 0);
            end
            @(negedge ck);
            for (int i = 0; i < N; i++)
                if (tiv[i] && tir[i]) q[i].push_back(model(W[i], ta[i], tbv[i], tci[i], tsub[i], cyc));
            @(posedge ck);
            #2;
        end
        for (int i = 0; i < N; i++) begin
            tiv[i] = 0; tordy[i] = 1;
        end
        idle(20);
        end_chk = 1;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
